// File: rtl/exp_avg_pkg.sv
// Shared types and helpers for the multi-channel exponential averager.
package exp_avg_pkg;

  // Default geometry; the top derives its accumulator width from its own parameters.
  localparam int unsigned W_DEF    = 12;
  localparam int unsigned KMAX_DEF = 5;
  localparam int unsigned ACCW     = W_DEF + KMAX_DEF;

  typedef enum logic {
    OP_SAMPLE = 1'b0,
    OP_SEED   = 1'b1
  } op_e;

  // Limit a requested weight shift to the largest supported shift.
  function automatic int unsigned clamp_k(input int unsigned k, input int unsigned kmax);
    return (k > kmax) ? kmax : k;
  endfunction

endpackage

// File: rtl/exp_avg_mc_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts one past the last grant.
module rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] last;

  // Rotating priority search starting at last+1.
  always_comb begin
    int unsigned j;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(last) + 1 + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  // Pointer resets to the last channel so the first search begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IW'(N - 1);
    end else if (|req) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/exp_avg_mc.sv
// N-channel exponential averager sharing one two-stage update datapath.
module exp_avg_mc
  import exp_avg_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned W    = 12,
  parameter int unsigned KMAX = 5,
  parameter int unsigned KW   = $clog2(KMAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  din,
  input  logic [NCH-1:0]    smpl_req,
  input  logic [NCH-1:0]    seed_req,
  input  logic [NCH*KW-1:0] wshift,
  input  logic              ovr_clr,
  output logic [NCH*W-1:0]  avg,
  output logic [NCH-1:0]    avg_vld,
  output logic [NCH-1:0]    upd,
  output logic [NCH-1:0]    ovr
);

  localparam int unsigned AW = W + KMAX;
  localparam int unsigned CW = $clog2(NCH);
  localparam logic [AW-1:0] ACC_MAX = {{W{1'b1}}, {KMAX{1'b0}}};

  logic [NCH-1:0] psmp, psd;
  logic [NCH-1:0] req, gnt, kchg, vld_eff, ovr_set;
  logic [CW-1:0]  gnt_idx;
  logic [KW-1:0]  kcl  [NCH];
  logic [KW-1:0]  kshd [NCH];
  logic [AW-1:0]  acc  [NCH];
  op_e            op_sel;

  logic           st_vld;
  logic [CW-1:0]  st_ch;
  op_e            st_op;
  logic [W-1:0]   st_din;
  logic [KW-1:0]  st_k;
  logic [AW-1:0]  acc_rd, acc_nx;

  // Clamped shifts, weight-change detect, and "seeded or being seeded" view.
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      kcl[c]     = KW'(clamp_k(32'(wshift[c*KW +: KW]), KMAX));
      kchg[c]    = (kcl[c] != kshd[c]);
      vld_eff[c] = avg_vld[c] | (st_vld && (st_ch == CW'(c)));
    end
  end

  assign req = psmp | psd;

  rr_arb #(.N(NCH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Granted op: pending seed, weight change or never-seeded channel all seed.
  always_comb begin
    op_sel = OP_SAMPLE;
    if (psd[gnt_idx] || kchg[gnt_idx] || !vld_eff[gnt_idx]) op_sel = OP_SEED;
  end

  // Overrun: a request hits an already-set flag that is not being granted.
  assign ovr_set = ((smpl_req & psmp) | (seed_req & psd)) & ~gnt;

  // Pending flags, shift shadows and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psmp <= '0;
      psd  <= '0;
      ovr  <= '0;
      for (int unsigned c = 0; c < NCH; c++) kshd[c] <= '0;
    end else begin
      psmp <= (psmp & ~gnt) | smpl_req;
      psd  <= (psd & ~gnt) | seed_req | (kchg & vld_eff & ~gnt);
      ovr  <= (ovr & ~{NCH{ovr_clr}}) | ovr_set;
      for (int unsigned c = 0; c < NCH; c++) kshd[c] <= kcl[c];
    end
  end

  // Stage 1: capture the granted channel, op, sample and shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_vld <= 1'b0;
      st_ch  <= '0;
      st_op  <= OP_SAMPLE;
      st_din <= '0;
      st_k   <= '0;
    end else begin
      st_vld <= |req;
      if (|req) begin
        st_ch  <= gnt_idx;
        st_op  <= op_sel;
        st_din <= din[32'(gnt_idx)*W +: W];
        st_k   <= kcl[gnt_idx];
      end
    end
  end

  // Stage 2 arithmetic: seed loads din<<k, sample folds din in with weight 2^-k.
  always_comb begin
    acc_rd = acc[st_ch];
    if (st_op == OP_SEED) acc_nx = AW'(st_din) << st_k;
    else                  acc_nx = acc_rd - (acc_rd >> st_k) + AW'(st_din);
  end

  // Stage 2 writeback of accumulator, average, valid and update pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg     <= '0;
      avg_vld <= '0;
      upd     <= '0;
      for (int unsigned c = 0; c < NCH; c++) acc[c] <= '0;
    end else begin
      upd <= '0;
      if (st_vld) begin
        acc[st_ch]                  <= acc_nx;
        avg[32'(st_ch)*W +: W]      <= W'(acc_nx >> st_k);
        avg_vld[st_ch]              <= 1'b1;
        upd[st_ch]                  <= 1'b1;
      end
    end
  end

  // Accumulators never exceed (2^W-1)*2^KMAX.
  for (genvar c = 0; c < NCH; c++) begin : g_bound
    a_acc_bound: assert property (@(posedge clk) disable iff (!rst_n) acc[c] <= ACC_MAX);
  end

endmodule
